// File: rtl/melody_game_engine_pkg.sv
// Shared types and helpers for the melody game engine: FSM states,
// game-mode codes, the default note type and small width/saturation helpers.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY_NOTE,
    S_PLAY_GAP,
    S_INPUT,
    S_DONE
  } state_e;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_MEMORY = 2'd1;
  localparam logic [1:0] MODE_RHYTHM = 2'd2;
  localparam logic [1:0] MODE_DONE   = 2'd3;

  localparam int unsigned NOTE_W_DEFAULT = 4;
  typedef logic [NOTE_W_DEFAULT-1:0] note_t;

  // Counter width able to index n distinct values, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/melody_game_engine_if.sv
// Control and display bundle between the debouncer/host side and the
// melody game engine.
interface melody_game_engine_if #(
  parameter int unsigned NOTE_W  = 4,
  parameter int unsigned SEQ_LEN = 8
);
  localparam int unsigned LVL_W = $clog2(SEQ_LEN + 1);

  logic                      load;
  logic [SEQ_LEN*NOTE_W-1:0] seq_data;
  logic                      mode_sel;
  logic                      start;
  logic                      answer_valid;
  logic [NOTE_W-1:0]         answer;

  logic [NOTE_W-1:0]         piezo_out;
  logic [NOTE_W-1:0]         led_out;
  logic                      miss_out;
  logic                      change_num_out;
  logic [1:0]                game_mode_out;
  logic [LVL_W-1:0]          level_out;
  logic [7:0]                score_out;
  logic [7:0]                miss_cnt_out;

  modport master (
    output load, seq_data, mode_sel, start, answer_valid, answer,
    input  piezo_out, led_out, miss_out, change_num_out, game_mode_out,
           level_out, score_out, miss_cnt_out
  );

  modport slave (
    input  load, seq_data, mode_sel, start, answer_valid, answer,
    output piezo_out, led_out, miss_out, change_num_out, game_mode_out,
           level_out, score_out, miss_cnt_out
  );
endinterface

// File: rtl/melody_game_engine_beat_tick.sv
// Beat prescaler: emits a one-cycle tick every TICK_DIV cycles and restarts
// its count whenever clr is asserted.
module beat_tick
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CNT_W = width_of(TICK_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/melody_game_engine.sv
// Two-mode melody game: memory mode replays a growing prefix of the melody and
// checks the player's echo; rhythm mode scores timed answers note by note.
module melody_game_engine
  import game_pkg::*;
#(
  parameter int unsigned NOTE_W        = NOTE_W_DEFAULT,
  parameter int unsigned SEQ_LEN       = 8,
  parameter int unsigned START_LEN     = 3,
  parameter int unsigned TICK_DIV      = 5000000,
  parameter int unsigned NOTE_BEATS    = 2,
  parameter int unsigned GAP_BEATS     = 1,
  parameter int unsigned TIMEOUT_BEATS = 3,
  parameter int unsigned ROUNDS        = 30
) (
  input logic                 clk,
  input logic                 reset,
  melody_game_engine_if.slave bus
);
  localparam int unsigned IDX_W  = width_of(SEQ_LEN);
  localparam int unsigned LVL_W  = $clog2(SEQ_LEN + 1);
  localparam int unsigned RND_W  = $clog2(ROUNDS + 1);
  localparam int unsigned BEAT_W = width_of(max3(NOTE_BEATS, GAP_BEATS, TIMEOUT_BEATS));

  localparam logic [BEAT_W-1:0] NOTE_LAST    = BEAT_W'(NOTE_BEATS - 1);
  localparam logic [BEAT_W-1:0] GAP_LAST     = BEAT_W'(GAP_BEATS - 1);
  localparam logic [BEAT_W-1:0] TIMEOUT_LAST = BEAT_W'(TIMEOUT_BEATS - 1);

  state_e                    state_q,     state_d;
  logic [SEQ_LEN*NOTE_W-1:0] notes_q,     notes_d;
  logic [1:0]                game_mode_q, game_mode_d;
  logic [IDX_W-1:0]          idx_q,       idx_d;
  logic [LVL_W-1:0]          level_q,     level_d;
  logic [RND_W-1:0]          round_q,     round_d;
  logic [BEAT_W-1:0]         beat_q,      beat_d;
  logic [NOTE_W-1:0]         piezo_q,     piezo_d;
  logic [NOTE_W-1:0]         led_q,       led_d;
  logic                      miss_q,      miss_d;
  logic                      chg_q,       chg_d;
  logic [7:0]                score_q,     score_d;
  logic [7:0]                miss_cnt_q,  miss_cnt_d;

  logic [NOTE_W-1:0] note_arr [SEQ_LEN];
  logic [IDX_W-1:0]  idx_next;
  logic              idx_at_last;
  logic              answer_hit;
  logic              tick;
  logic              restart;
  logic              replay;
  logic              rhy_step;
  logic              rhy_hit;
  logic              miss_evt;

  beat_tick #(.TICK_DIV(TICK_DIV)) u_beat_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (restart),
    .tick  (tick)
  );

  always_comb begin
    for (int i = 0; i < SEQ_LEN; i++) note_arr[i] = notes_q[i*NOTE_W +: NOTE_W];
  end

  // The same index walks the memory prefix and, wrapping, the rhythm melody.
  assign idx_next    = (idx_q == IDX_W'(SEQ_LEN - 1)) ? '0 : idx_q + 1'b1;
  assign idx_at_last = (LVL_W'(idx_q) == level_q - 1'b1);
  assign answer_hit  = (bus.answer == note_arr[idx_q]);

  always_comb begin
    // NOTE: every *_d and flag gets its held/idle value first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    state_d     = state_q;
    notes_d     = notes_q;
    game_mode_d = game_mode_q;
    idx_d       = idx_q;
    level_d     = level_q;
    round_d     = round_q;
    beat_d      = beat_q;
    piezo_d     = piezo_q;
    led_d       = led_q;
    miss_d      = 1'b0;
    chg_d       = 1'b0;
    score_d     = score_q;
    miss_cnt_d  = miss_cnt_q;
    restart     = 1'b0;
    replay      = 1'b0;
    rhy_step    = 1'b0;
    rhy_hit     = 1'b0;
    miss_evt    = 1'b0;

    if (bus.load) begin
      notes_d     = bus.seq_data;
      state_d     = S_IDLE;
      game_mode_d = MODE_IDLE;
      piezo_d     = '0;
      led_d       = '0;
      idx_d       = '0;
      beat_d      = '0;
      restart     = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            score_d    = '0;
            miss_cnt_d = '0;
            level_d    = LVL_W'(START_LEN);
            idx_d      = '0;
            round_d    = '0;
            beat_d     = '0;
            restart    = 1'b1;
            if (bus.mode_sel) begin
              state_d     = S_INPUT;
              game_mode_d = MODE_RHYTHM;
              led_d       = note_arr[0];
              piezo_d     = '0;
              chg_d       = 1'b1;
            end else begin
              state_d     = S_PLAY_NOTE;
              game_mode_d = MODE_MEMORY;
              led_d       = note_arr[0];
              piezo_d     = note_arr[0];
            end
          end
        end

        S_PLAY_NOTE: begin
          if (tick) begin
            if (beat_q == NOTE_LAST) begin
              state_d = S_PLAY_GAP;
              piezo_d = '0;
              led_d   = '0;
              beat_d  = '0;
              restart = 1'b1;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end

        S_PLAY_GAP: begin
          if (tick) begin
            if (beat_q == GAP_LAST) begin
              beat_d  = '0;
              restart = 1'b1;
              if (idx_at_last) begin
                idx_d   = '0;
                state_d = S_INPUT;
              end else begin
                idx_d   = idx_next;
                state_d = S_PLAY_NOTE;
                piezo_d = note_arr[idx_next];
                led_d   = note_arr[idx_next];
              end
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end

        S_INPUT: begin
          // An answer takes priority over a timeout tick landing in the same cycle.
          if (bus.answer_valid) begin
            beat_d  = '0;
            restart = 1'b1;
            if (game_mode_q == MODE_RHYTHM) begin
              rhy_step = 1'b1;
              rhy_hit  = answer_hit;
            end else if (!answer_hit) begin
              miss_evt = 1'b1;
              replay   = 1'b1;
            end else if (!idx_at_last) begin
              idx_d = idx_next;
              led_d = bus.answer;
            end else if (level_q == LVL_W'(SEQ_LEN)) begin
              game_mode_d = MODE_RHYTHM;
              round_d     = '0;
              idx_d       = '0;
              led_d       = note_arr[0];
              piezo_d     = '0;
              chg_d       = 1'b1;
            end else begin
              level_d = level_q + 1'b1;
              replay  = 1'b1;
            end
          end else if (tick) begin
            if (beat_q == TIMEOUT_LAST) begin
              beat_d  = '0;
              restart = 1'b1;
              if (game_mode_q == MODE_RHYTHM) begin
                rhy_step = 1'b1;
              end else begin
                miss_evt = 1'b1;
                replay   = 1'b1;
              end
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase

      if (replay) begin
        idx_d   = '0;
        state_d = S_PLAY_NOTE;
        piezo_d = note_arr[0];
        led_d   = note_arr[0];
      end

      if (rhy_step) begin
        if (rhy_hit) score_d = sat_inc(score_q);
        else         miss_evt = 1'b1;
        if (round_q == RND_W'(ROUNDS - 1)) begin
          state_d     = S_DONE;
          game_mode_d = MODE_DONE;
          led_d       = '0;
          piezo_d     = '0;
        end else begin
          round_d = round_q + 1'b1;
          idx_d   = idx_next;
          led_d   = note_arr[idx_next];
          chg_d   = 1'b1;
        end
      end

      if (miss_evt) begin
        miss_d     = 1'b1;
        miss_cnt_d = sat_inc(miss_cnt_q);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      // NOTE: the melody store is small, so it is reset along with the control
      // state; playback before the first load then sounds silence, not X.
      notes_q     <= '0;
      game_mode_q <= MODE_IDLE;
      idx_q       <= '0;
      level_q     <= LVL_W'(START_LEN);
      round_q     <= '0;
      beat_q      <= '0;
      piezo_q     <= '0;
      led_q       <= '0;
      miss_q      <= 1'b0;
      chg_q       <= 1'b0;
      score_q     <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      notes_q     <= notes_d;
      game_mode_q <= game_mode_d;
      idx_q       <= idx_d;
      level_q     <= level_d;
      round_q     <= round_d;
      beat_q      <= beat_d;
      piezo_q     <= piezo_d;
      led_q       <= led_d;
      miss_q      <= miss_d;
      chg_q       <= chg_d;
      score_q     <= score_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign bus.piezo_out      = piezo_q;
  assign bus.led_out        = led_q;
  assign bus.miss_out       = miss_q;
  assign bus.change_num_out = chg_q;
  assign bus.game_mode_out  = game_mode_q;
  assign bus.level_out      = level_q;
  assign bus.score_out      = score_q;
  assign bus.miss_cnt_out   = miss_cnt_q;

endmodule

// File: tb/tb_melody_game_engine.sv
// Directed bench for melody_game_engine with a small, fast-ticking configuration;
// expected values are worked out by hand from the game rules.
module tb_melody_game_engine;
  import game_pkg::*;

  localparam int unsigned NOTE_W        = 4;
  localparam int unsigned SEQ_LEN       = 4;
  localparam int unsigned START_LEN     = 2;
  localparam int unsigned TICK_DIV      = 4;
  localparam int unsigned NOTE_BEATS    = 2;
  localparam int unsigned GAP_BEATS     = 1;
  localparam int unsigned TIMEOUT_BEATS = 3;
  localparam int unsigned ROUNDS        = 6;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  melody_game_engine_if #(.NOTE_W(NOTE_W), .SEQ_LEN(SEQ_LEN)) bus ();

  melody_game_engine #(
    .NOTE_W        (NOTE_W),
    .SEQ_LEN       (SEQ_LEN),
    .START_LEN     (START_LEN),
    .TICK_DIV      (TICK_DIV),
    .NOTE_BEATS    (NOTE_BEATS),
    .GAP_BEATS     (GAP_BEATS),
    .TIMEOUT_BEATS (TIMEOUT_BEATS),
    .ROUNDS        (ROUNDS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1 time unit after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic give(input note_t a);
    bus.answer       = a;
    bus.answer_valid = 1'b1;
    step(1);
    bus.answer_valid = 1'b0;
  endtask

  // Playback of a prefix whose note i is base+i: 8 cycles sounding, 4 silent per note.
  function automatic logic [31:0] play_exp(input int c, input int base);
    return ((c % 12) < 8) ? 32'(base + c / 12) : 32'd0;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    bus.load = 1'b0;
    bus.seq_data = '0;
    bus.mode_sel = 1'b0;
    bus.start = 1'b0;
    bus.answer_valid = 1'b0;
    bus.answer = '0;
    reset = 1'b1;
    step(2);
    reset = 1'b0;

    check("rst_piezo", bus.piezo_out, 0);
    check("rst_led", bus.led_out, 0);
    check("rst_miss", bus.miss_out, 0);
    check("rst_chg", bus.change_num_out, 0);
    check("rst_mode", bus.game_mode_out, MODE_IDLE);
    check("rst_level", bus.level_out, START_LEN);
    check("rst_score", bus.score_out, 0);
    check("rst_misscnt", bus.miss_cnt_out, 0);

    // Scenario 1: memory start plays notes 1 and 2
    bus.seq_data = 16'h4321;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("load_mode", bus.game_mode_out, MODE_IDLE);
    bus.mode_sel = 1'b0;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("s1_mode", bus.game_mode_out, MODE_MEMORY);
    check("s1_level", bus.level_out, 2);
    check("s1_led0", bus.led_out, 1);
    for (int c = 0; c < 24; c++) begin
      check($sformatf("s1_piezo_c%0d", c), bus.piezo_out, play_exp(c, 1));
      step(1);
    end
    check("s1_input_piezo", bus.piezo_out, 0);
    check("s1_input_led", bus.led_out, 0);

    // Scenario 2: level up, replay of three notes, then a wrong answer
    give(1);
    check("s2_echo1", bus.led_out, 1);
    check("s2_nomiss", bus.miss_out, 0);
    give(2);
    check("s2_level3", bus.level_out, 3);
    for (int c = 0; c < 36; c++) begin
      check($sformatf("s2_piezo_c%0d", c), bus.piezo_out, play_exp(c, 1));
      step(1);
    end
    give(1);
    check("s2_echo1b", bus.led_out, 1);
    give(4);
    check("s2_miss", bus.miss_out, 1);
    check("s2_misscnt", bus.miss_cnt_out, 1);
    check("s2_level_hold", bus.level_out, 3);
    check("s2_replay", bus.piezo_out, 1);
    step(1);
    check("s2_miss_pulse", bus.miss_out, 0);
    step(35);

    // Scenario 3: timeout 12 cycles after INPUT entry, then an answer on the tick
    step(11);
    check("s3_no_early_miss", bus.miss_out, 0);
    check("s3_silent", bus.piezo_out, 0);
    step(1);
    check("s3_timeout_miss", bus.miss_out, 1);
    check("s3_timeout_cnt", bus.miss_cnt_out, 2);
    check("s3_timeout_replay", bus.piezo_out, 1);
    step(36);
    step(11);
    give(1);
    check("s3_coinc_nomiss", bus.miss_out, 0);
    check("s3_coinc_led", bus.led_out, 1);
    check("s3_coinc_cnt", bus.miss_cnt_out, 2);
    check("s3_coinc_input", bus.piezo_out, 0);
    give(2);
    check("s3_echo2", bus.led_out, 2);
    give(3);
    check("s3_level4", bus.level_out, 4);
    check("s3_replay4", bus.piezo_out, 1);
    step(48);

    // Scenario 4: completing the full melody switches to rhythm mode
    give(1);
    give(2);
    give(3);
    check("s4_echo3", bus.led_out, 3);
    give(4);
    check("s4_chg", bus.change_num_out, 1);
    check("s4_mode", bus.game_mode_out, MODE_RHYTHM);
    check("s4_led", bus.led_out, 1);
    check("s4_piezo", bus.piezo_out, 0);
    check("s4_level", bus.level_out, 4);
    step(1);
    check("s4_chg_pulse", bus.change_num_out, 0);

    // Scenario 5: fresh rhythm game; load beats a simultaneous start
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("s5_load_mode", bus.game_mode_out, MODE_IDLE);
    check("s5_load_led", bus.led_out, 0);
    check("s5_load_cnt_hold", bus.miss_cnt_out, 2);
    bus.mode_sel = 1'b1;
    bus.load = 1'b1;
    bus.start = 1'b1;
    step(1);
    bus.load = 1'b0;
    bus.start = 1'b0;
    check("s5_loadwins_mode", bus.game_mode_out, MODE_IDLE);
    check("s5_loadwins_chg", bus.change_num_out, 0);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("s5_chg0", bus.change_num_out, 1);
    check("s5_mode", bus.game_mode_out, MODE_RHYTHM);
    check("s5_led0", bus.led_out, 1);
    check("s5_piezo0", bus.piezo_out, 0);
    check("s5_score0", bus.score_out, 0);
    check("s5_cnt0", bus.miss_cnt_out, 0);
    check("s5_level", bus.level_out, START_LEN);
    give(1);
    check("s5_r0_score", bus.score_out, 1);
    check("s5_r0_chg", bus.change_num_out, 1);
    check("s5_r0_led", bus.led_out, 2);
    check("s5_r0_nomiss", bus.miss_out, 0);
    give(9);
    check("s5_r1_miss", bus.miss_out, 1);
    check("s5_r1_cnt", bus.miss_cnt_out, 1);
    check("s5_r1_led", bus.led_out, 3);
    check("s5_r1_score", bus.score_out, 1);
    step(11);
    check("s5_r2_wait_miss", bus.miss_out, 0);
    check("s5_r2_wait_chg", bus.change_num_out, 0);
    step(1);
    check("s5_r2_miss", bus.miss_out, 1);
    check("s5_r2_cnt", bus.miss_cnt_out, 2);
    check("s5_r2_led", bus.led_out, 4);
    check("s5_r2_chg", bus.change_num_out, 1);
    give(4);
    check("s5_r3_score", bus.score_out, 2);
    check("s5_r3_led_wrap", bus.led_out, 1);
    give(1);
    check("s5_r4_score", bus.score_out, 3);
    check("s5_r4_led", bus.led_out, 2);
    give(2);
    check("s5_done_score", bus.score_out, 4);
    check("s5_done_mode", bus.game_mode_out, MODE_DONE);
    check("s5_done_led", bus.led_out, 0);
    check("s5_done_chg", bus.change_num_out, 0);
    check("s5_done_cnt", bus.miss_cnt_out, 2);
    give(2);
    check("s5_done_ignore", bus.score_out, 4);
    step(20);
    check("s5_done_hold_mode", bus.game_mode_out, MODE_DONE);
    check("s5_done_hold_miss", bus.miss_out, 0);
    check("s5_done_hold_cnt", bus.miss_cnt_out, 2);

    // Scenario 6: new melody, load mid-playback, reset during INPUT
    bus.seq_data = 16'h8765;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("s6_load_mode", bus.game_mode_out, MODE_IDLE);
    check("s6_load_score_hold", bus.score_out, 4);
    bus.mode_sel = 1'b0;
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("s6_newnote", bus.piezo_out, 5);
    check("s6_score_clr", bus.score_out, 0);
    check("s6_cnt_clr", bus.miss_cnt_out, 0);
    step(3);
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check("s6_midload_mode", bus.game_mode_out, MODE_IDLE);
    check("s6_midload_piezo", bus.piezo_out, 0);
    check("s6_midload_led", bus.led_out, 0);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    for (int c = 0; c < 24; c++) begin
      check($sformatf("s6_piezo_c%0d", c), bus.piezo_out, play_exp(c, 5));
      step(1);
    end
    give(5);
    check("s6_echo5", bus.led_out, 5);
    check("s6_mode_mem", bus.game_mode_out, MODE_MEMORY);
    reset = 1'b1;
    bus.answer = 4'd6;
    bus.answer_valid = 1'b1;
    step(1);
    reset = 1'b0;
    bus.answer_valid = 1'b0;
    check("s6_rst_piezo", bus.piezo_out, 0);
    check("s6_rst_led", bus.led_out, 0);
    check("s6_rst_miss", bus.miss_out, 0);
    check("s6_rst_chg", bus.change_num_out, 0);
    check("s6_rst_mode", bus.game_mode_out, MODE_IDLE);
    check("s6_rst_level", bus.level_out, START_LEN);
    check("s6_rst_score", bus.score_out, 0);
    check("s6_rst_cnt", bus.miss_cnt_out, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
